dmem_boot_loader: RTL and testbench
===================================

Name: dmem_boot_loader

Overview:
- Boot-time front end for the 16x8 data memory; sits directly upstream of it and drives its write-enable (c17), write address, write data and read address.
- Accepts a byte stream over a valid/ready handshake, writes DEPTH consecutive bytes from address 0, then reads them back to check a running checksum.
- Outside a load, CPU data-memory requests pass straight through to the memory.

Parameters:
- DEPTH, 16, number of bytes loaded (addresses 0..DEPTH-1).
- ADDR_W, 4, address width; DEPTH <= 2**ADDR_W.
- DATA_W, 8, data width.
- VERIFY, 1, 1 = run readback verify after load; 0 = go straight to DONE.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  level-sampled request to begin a load; acted on in IDLE or DONE only.
- in_valid  in  1  source has a byte.
- in_data  in  DATA_W  byte to load.
- in_ready  out  1  loader accepts a byte; a beat is in_valid & in_ready.
- cpu_we  in  1  CPU write enable.
- cpu_waddr  in  ADDR_W  CPU write address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_raddr  in  ADDR_W  CPU read address.
- mem_we  out  1  to memory c17.
- mem_waddr  out  ADDR_W  to memory write_select.
- mem_wdata  out  DATA_W  to memory inp.
- mem_raddr  out  ADDR_W  to memory read_select.
- mem_rdata  in  DATA_W  from memory output; registered, valid the cycle after mem_raddr is presented.
- busy  out  1  high in LOAD/VERIFY; CPU must stall.
- done  out  1  load finished (sticky until next start or reset).
- error  out  1  verify mismatch (sticky until next start or reset).
- checksum  out  DATA_W  sum mod 2**DATA_W of bytes loaded.

Behaviour:
- Reset is asynchronous and active-high. On reset: state=IDLE, ptr=0, checksum=0, rsum=0, busy=0, done=0, error=0, in_ready=0. Memory contents are not touched by this block.
- States: IDLE, LOAD, VERIFY, DONE.
- IDLE / DONE (pass-through, combinational):
  - mem_we=cpu_we, mem_waddr=cpu_waddr, mem_wdata=cpu_wdata, mem_raddr=cpu_raddr.
  - in_ready=0.
  - start=1 -> LOAD next edge; ptr, checksum, rsum cleared; done and error cleared.
- LOAD:
  - in_ready=1, busy=1. mem_we=in_valid, mem_waddr=ptr, mem_wdata=in_data (combinational, zero added latency).
  - CPU inputs ignored (CPU writes dropped); mem_raddr=cpu_raddr.
  - Each beat: checksum+=in_data (wraps), ptr+=1.
  - Beat with ptr=DEPTH-1 -> VERIFY (VERIFY=1) or DONE with done=1 (VERIFY=0); ptr cleared.
  - in_valid gaps stall LOAD indefinitely; there is no timeout.
- VERIFY (DEPTH+1 cycles, in_ready=0, mem_we=0, busy=1):
  - Cycle k (k=0..DEPTH-1): mem_raddr=k.
  - Cycle k (k=1..DEPTH): rsum+=mem_rdata, which returns address k-1.
  - At the end of cycle DEPTH -> DONE; done=1; error=1 iff the final rsum != checksum.
- start while busy is ignored. start held high in DONE restarts a load every time it is sampled.
- DONE is entered on the same edge that sets done=1. busy falls on that edge.
- Reset mid-LOAD/VERIFY aborts immediately to IDLE; the memory keeps any partial writes.
- Arithmetic: all sums are DATA_W wide, modulo 2**DATA_W. ptr is ADDR_W+1 wide to avoid wrap ambiguity when DEPTH=2**ADDR_W.

Decomposition:
- Shared package dmem_pkg: DATA_W/ADDR_W/DEPTH defaults; state enum (IDLE=2'd0, LOAD=2'd1, VERIFY=2'd2, DONE=2'd3).
- One natural sub-module: dmem_port_mux, the combinational selection of mem_* between CPU and loader based on state. The FSM, counters and sums stay in the top.

Test Plan:
- Load bytes 0x00..0x0F back-to-back after start -> 16 mem_we pulses at addresses 0..15; checksum=0x78; done after 16+17 cycles; error=0; memory model holds i at address i.
- Same load with in_valid deasserted every other cycle -> identical memory contents and checksum; in_ready high throughout LOAD; no write on idle cycles.
- Load 0xFF x16 -> checksum=0xF0 (wraps); error=0.
- Bench flips bit 0 of mem_rdata while mem_rdata returns address 5 during VERIFY -> done=1, error=1.
- Assert reset after the 7th beat -> busy=0, in_ready=0, done=0, checksum=0 immediately (async). A following start reloads cleanly.
- In DONE, cpu_we=1, cpu_waddr=3, cpu_wdata=0xAA -> mem_we=1, address 3 written with 0xAA. The same request during LOAD -> not forwarded.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared defaults and state encoding for the data-memory boot loader.
package dmem_pkg;

  localparam int DMEM_DEPTH  = 16;
  localparam int DMEM_ADDR_W = 4;
  localparam int DMEM_DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // The CPU owns the memory port whenever the loader is not busy.
  function automatic logic is_passthrough(input state_t s);
    return (s == S_IDLE) || (s == S_DONE);
  endfunction

endpackage

// File: rtl/dmem_port_mux.sv
// Combinational selection of the memory port between the CPU and the loader.
module dmem_port_mux
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  state_t              state,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_waddr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [ADDR_W-1:0]   cpu_raddr,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [ADDR_W-1:0]   mem_raddr
);

  // LOAD writes straight from the input stream; VERIFY only reads.
  always_comb begin
    mem_we    = cpu_we;
    mem_waddr = cpu_waddr;
    mem_wdata = cpu_wdata;
    mem_raddr = cpu_raddr;
    if (!is_passthrough(state)) begin
      mem_waddr = load_addr;
      mem_wdata = in_data;
      if (state == S_LOAD) begin
        mem_we = in_valid;
      end else begin
        mem_we    = 1'b0;
        mem_raddr = load_addr;
      end
    end
  end

endmodule

// File: rtl/dmem_boot_loader.sv
// Boot-time loader: streams DEPTH bytes into the data memory from address 0,
// then optionally reads them back and compares against the running checksum.
module dmem_boot_loader
  import dmem_pkg::*;
#(
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int VERIFY = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_waddr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic [ADDR_W-1:0]   cpu_raddr,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [ADDR_W-1:0]   mem_raddr,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [DATA_W-1:0]   checksum
);

  localparam logic [ADDR_W:0] PTR_LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] PTR_END  = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W:0]   ptr;
  logic [DATA_W-1:0] rsum;

  // ptr doubles as the write pointer in LOAD and the readback cycle index in
  // VERIFY; in VERIFY each read result lands one cycle after its address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      checksum <= '0;
      rsum     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state    <= S_LOAD;
            ptr      <= '0;
            checksum <= '0;
            rsum     <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            checksum <= checksum + in_data;
            if (ptr == PTR_LAST) begin
              ptr      <= '0;
              in_ready <= 1'b0;
              if (VERIFY != 0) begin
                state <= S_VERIFY;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
            end else begin
              ptr <= ptr + 1'b1;
            end
          end
        end
        S_VERIFY: begin
          if (ptr != '0) begin
            rsum <= rsum + mem_rdata;
          end
          if (ptr == PTR_END) begin
            state <= S_DONE;
            ptr   <= '0;
            done  <= 1'b1;
            busy  <= 1'b0;
            error <= ((rsum + mem_rdata) != checksum);
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  dmem_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_port_mux (
    .state     (state),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .load_addr (ptr[ADDR_W-1:0]),
    .cpu_we    (cpu_we),
    .cpu_waddr (cpu_waddr),
    .cpu_wdata (cpu_wdata),
    .cpu_raddr (cpu_raddr),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_raddr (mem_raddr)
  );

endmodule

// File: tb/tb_dmem_boot_loader.sv
// Self-checking bench for dmem_boot_loader with a 16x8 registered-read memory model.
module tb_dmem_boot_loader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       cpu_we = 1'b0;
  logic [3:0] cpu_waddr = 4'h0;
  logic [7:0] cpu_wdata = 8'h00;
  logic [3:0] cpu_raddr = 4'h0;
  logic       mem_we;
  logic [3:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [3:0] mem_raddr;
  logic [7:0] mem_rdata = 8'h00;
  logic       busy, done, error;
  logic [7:0] checksum;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] mem [16];
  logic [7:0] load_bytes [16];
  logic       flip_en = 1'b0;
  int         checks = 0;
  int         passes = 0;

  always #5 clock = ~clock;

  dmem_boot_loader dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cpu_we    (cpu_we),
    .cpu_waddr (cpu_waddr),
    .cpu_wdata (cpu_wdata),
    .cpu_raddr (cpu_raddr),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .checksum  (checksum)
  );

  // Memory model; flip_en corrupts bit 0 of address 5 when read during VERIFY.
  always @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (flip_en && busy && !in_ready && mem_raddr == 4'd5)
      mem_rdata <= mem[mem_raddr] ^ 8'h01;
    else
      mem_rdata <= mem[mem_raddr];
  end

  task automatic run_load(input bit gaps, input logic exp_error, input string tag);
    int         idx;
    int         cyc;
    int         n;
    logic [7:0] sum;
    wr_t        got;
    sum = 8'h00;
    exp_q.delete();
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1)
      $display("[TB] FAIL %s_enter_load: busy=%b in_ready=%b want 1 1", tag, busy, in_ready);
    else passes++;
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 200) begin
      if (gaps && cyc[0]) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = load_bytes[idx];
        exp_q.push_back({idx[3:0], load_bytes[idx]});
        sum = sum + load_bytes[idx];
      end
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b1 || mem_we !== in_valid)
        $display("[TB] FAIL %s_beat%0d: in_ready=%b mem_we=%b want 1 %b", tag, cyc, in_ready, mem_we, in_valid);
      else passes++;
      if (mem_we === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL %s_write: unexpected write addr=%h data=%h", tag, mem_waddr, mem_wdata);
        end else begin
          got = exp_q.pop_front();
          if (mem_waddr !== got.addr || mem_wdata !== got.data)
            $display("[TB] FAIL %s_write: got %h/%h want %h/%h", tag, mem_waddr, mem_wdata, got.addr, got.data);
          else passes++;
        end
      end
      if (in_valid) idx++;
      @(posedge clock); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (idx != 16 || exp_q.size() != 0)
      $display("[TB] FAIL %s_beats: accepted %0d pending %0d want 16 0", tag, idx, exp_q.size());
    else passes++;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (n != 17) $display("[TB] FAIL %s_verify_len: %0d cycles want 17", tag, n);
    else passes++;
    checks++;
    if (checksum !== sum) $display("[TB] FAIL %s_checksum: got %h want %h", tag, checksum, sum);
    else passes++;
    checks++;
    if (error !== exp_error || busy !== 1'b0 || in_ready !== 1'b0)
      $display("[TB] FAIL %s_status: error=%b busy=%b in_ready=%b want %b 0 0", tag, error, busy, in_ready, exp_error);
    else passes++;
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (mem[a] !== load_bytes[a])
        $display("[TB] FAIL %s_mem[%0d]: got %h want %h", tag, a, mem[a], load_bytes[a]);
      else passes++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_raddr = 4'd7;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || in_ready !== 1'b0 || checksum !== 8'h00)
      $display("[TB] FAIL reset_state: busy=%b done=%b error=%b in_ready=%b checksum=%h want all 0",
               busy, done, error, in_ready, checksum);
    else passes++;
    checks++;
    if (mem_raddr !== 4'd7) $display("[TB] FAIL reset_raddr_pass: got %h want 7", mem_raddr);
    else passes++;
    cpu_raddr = 4'd0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'(i);
    run_load(1'b0, 1'b0, "b2b");
  endtask

  task automatic test_gapped();
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'(i);
    run_load(1'b1, 1'b0, "gap");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'hFF;
    run_load(1'b0, 1'b0, "wrap");
  endtask

  task automatic test_verify_error();
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'(8'h30 + 8'(i * 3));
    flip_en = 1'b1;
    run_load(1'b0, 1'b1, "corrupt");
    flip_en = 1'b0;
  endtask

  task automatic test_cpu_passthrough();
    @(posedge clock); #1;
    cpu_we = 1'b1; cpu_waddr = 4'd3; cpu_wdata = 8'hAA;
    @(negedge clock);
    checks++;
    if (mem_we !== 1'b1 || mem_waddr !== 4'd3 || mem_wdata !== 8'hAA)
      $display("[TB] FAIL cpu_pass: we=%b addr=%h data=%h want 1 3 aa", mem_we, mem_waddr, mem_wdata);
    else passes++;
    @(posedge clock); #1;
    cpu_we = 1'b0;
    checks++;
    if (mem[3] !== 8'hAA) $display("[TB] FAIL cpu_pass_mem: got %h want aa", mem[3]);
    else passes++;
  endtask

  task automatic test_abort_reset();
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'(8'hA0 + 8'(i));
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = load_bytes[i];
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    cpu_we = 1'b1; cpu_waddr = 4'd3; cpu_wdata = 8'h55;
    @(negedge clock);
    checks++;
    if (mem_we !== 1'b0) $display("[TB] FAIL cpu_drop_in_load: mem_we=%b want 0", mem_we);
    else passes++;
    @(posedge clock); #1;
    cpu_we = 1'b0;
    checks++;
    if (mem[3] !== 8'hA3) $display("[TB] FAIL cpu_drop_mem: got %h want a3", mem[3]);
    else passes++;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || checksum !== 8'h00)
      $display("[TB] FAIL abort_async: busy=%b in_ready=%b done=%b checksum=%h want 0 0 0 00",
               busy, in_ready, done, checksum);
    else passes++;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (mem[6] !== 8'hA6) $display("[TB] FAIL abort_partial: got %h want a6", mem[6]);
    else passes++;
    for (int i = 0; i < 16; i++) load_bytes[i] = 8'(8'h11 * 8'(i));
    run_load(1'b0, 1'b0, "reload");
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_cpu_passthrough();
    test_gapped();
    test_wrap();
    test_verify_error();
    test_abort_reset();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
